// File: rtl/sad_ctrl_pkg.sv
// Shared types for the SAD search sequencer: FSM states, the "no minimum yet"
// sentinel, and the packed candidate position carried through the result FIFO.
package sad_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] SUM_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
  } pos_t;

endpackage

// File: rtl/sad_min_tracker.sv
// Position FIFO plus running minimum; a popped result updates the minimum on the next edge.
// No backpressure of its own: the sequencer never pushes more than DEPTH entries in flight.
module sad_min_tracker
  import sad_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic [7:0]  row_i,
  input  logic [7:0]  col_i,
  input  logic        pop_i,
  input  logic [31:0] sum_i,
  output logic [31:0] min_sum_o,
  output logic [7:0]  min_row_o,
  output logic [7:0]  min_col_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pos_t            fifo_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [31:0]     min_q;
  pos_t            min_pos_q;
  pos_t            head;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign head = fifo_q[rd_q];

  // Strict less-than keeps the earliest raster position on ties.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      min_q     <= SUM_MAX;
      min_pos_q <= '0;
    end else if (clr_i) begin
      wr_q      <= '0;
      rd_q      <= '0;
      min_q     <= SUM_MAX;
      min_pos_q <= '0;
    end else begin
      if (push_i) begin
        fifo_q[wr_q] <= '{row: row_i, col: col_i};
        wr_q         <= nxt(wr_q);
      end
      if (pop_i) begin
        rd_q <= nxt(rd_q);
        if (sum_i < min_q) begin
          min_q     <= sum_i;
          min_pos_q <= head;
        end
      end
    end
  end

  assign min_sum_o = min_q;
  assign min_row_o = min_pos_q.row;
  assign min_col_o = min_pos_q.col;

endmodule

// File: rtl/sad_search_ctrl.sv
// Raster-order block-matching sequencer: one SAD request per candidate, min of returned sums.
// Issue stalls on SadReady low or MAX_OUT in flight; Done one cycle after the last result.
module sad_search_ctrl
  import sad_ctrl_pkg::*;
#(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int WIN     = 4,
  parameter int MAX_OUT = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] FrameBase,
  input  logic        SadReady,
  output logic        SadIssue,
  output logic [31:0] SadAddr,
  input  logic        SumValid,
  input  logic [31:0] Sum,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] MinSum,
  output logic [7:0]  MinRow,
  output logic [7:0]  MinCol
);

  localparam int NROW = FRAME_H - WIN + 1;
  localparam int NCOL = FRAME_W - WIN + 1;
  localparam int N    = NROW * NCOL;
  localparam int CW   = $clog2(N + 1);
  localparam int OW   = $clog2(MAX_OUT + 1);

  state_t          state_q;
  logic [31:0]     addr_q;
  logic [7:0]      row_q, col_q;
  logic [CW-1:0]   iss_cnt_q, ret_cnt_q, ret_cnt_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic            busy_q, done_q;
  logic            run, issue, accept, ret, start_acc;

  // A same-cycle return frees a slot, so a full pipeline can still issue.
  always_comb begin
    run       = (state_q == ISSUE) || (state_q == DRAIN);
    issue     = (state_q == ISSUE) && ((outst_q < OW'(MAX_OUT)) || SumValid);
    accept    = issue && SadReady;
    ret       = run && SumValid && (outst_q != '0);
    start_acc = (state_q == IDLE) && Start;
    ret_cnt_d = ret_cnt_q + CW'(ret);
    outst_d   = outst_q + OW'(accept) - OW'(ret);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      iss_cnt_q <= '0;
      ret_cnt_q <= '0;
      outst_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            state_q   <= ISSUE;
            busy_q    <= 1'b1;
            addr_q    <= FrameBase;
            row_q     <= '0;
            col_q     <= '0;
            iss_cnt_q <= '0;
            ret_cnt_q <= '0;
            outst_q   <= '0;
          end
        end
        ISSUE: begin
          outst_q   <= outst_d;
          ret_cnt_q <= ret_cnt_d;
          if (accept) begin
            iss_cnt_q <= iss_cnt_q + CW'(1);
            if (iss_cnt_q == CW'(N - 1)) begin
              state_q <= DRAIN;
            end else if (col_q == 8'(NCOL - 1)) begin
              // Row wrap skips the WIN-1 columns that cannot host a block.
              col_q  <= '0;
              row_q  <= row_q + 8'd1;
              addr_q <= addr_q + 32'(WIN * 4);
            end else begin
              col_q  <= col_q + 8'd1;
              addr_q <= addr_q + 32'd4;
            end
          end
        end
        DRAIN: begin
          outst_q   <= outst_d;
          ret_cnt_q <= ret_cnt_d;
          if (ret_cnt_d == CW'(N)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  sad_min_tracker #(.DEPTH(MAX_OUT)) u_tracker (
    .clk_i     (Clk),
    .rst_ni    (Reset),
    .clr_i     (start_acc),
    .push_i    (accept),
    .row_i     (row_q),
    .col_i     (col_q),
    .pop_i     (ret),
    .sum_i     (Sum),
    .min_sum_o (MinSum),
    .min_row_o (MinRow),
    .min_col_o (MinCol)
  );

  assign SadIssue = issue;
  assign SadAddr  = addr_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Scoreboard bench: expected issue addresses and search results are queued by the stimulus,
// a negedge monitor pops and compares them whenever the DUT issues or pulses Done.
module tb_sad_search_ctrl;

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset, Start, SadReady, SumValid;
  logic [31:0] FrameBase, Sum;
  logic        SadIssue, Busy, Done;
  logic [31:0] SadAddr, MinSum;
  logic [7:0]  MinRow, MinCol;

  logic        Start_b, SadReady_b, SumValid_b;
  logic [31:0] FrameBase_b, Sum_b;
  logic        SadIssue_b, Busy_b, Done_b;
  logic [31:0] SadAddr_b, MinSum_b;
  logic [7:0]  MinRow_b, MinCol_b;

  sad_search_ctrl #(.FRAME_W(8), .FRAME_H(8), .WIN(4), .MAX_OUT(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .FrameBase(FrameBase),
    .SadReady(SadReady), .SadIssue(SadIssue), .SadAddr(SadAddr),
    .SumValid(SumValid), .Sum(Sum), .Busy(Busy), .Done(Done),
    .MinSum(MinSum), .MinRow(MinRow), .MinCol(MinCol)
  );

  sad_search_ctrl #(.FRAME_W(8), .FRAME_H(8), .WIN(8), .MAX_OUT(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(Start_b), .FrameBase(FrameBase_b),
    .SadReady(SadReady_b), .SadIssue(SadIssue_b), .SadAddr(SadAddr_b),
    .SumValid(SumValid_b), .Sum(Sum_b), .Busy(Busy_b), .Done(Done_b),
    .MinSum(MinSum_b), .MinRow(MinRow_b), .MinCol(MinCol_b)
  );

  typedef struct packed {
    logic [31:0] s;
    logic [7:0]  r;
    logic [7:0]  c;
  } res_t;

  typedef struct {
    int          due;
    logic [31:0] s;
  } pend_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_addr_q [$];
  res_t        exp_res_q [$];
  pend_t       pend_q [$];
  int          cyc_n = 0, acc_cnt = 0, mon_iss = 0, done_cnt = 0, outst_tb = 0;
  int          mode = 0, ready_mode = 0, hold = 0;
  bit          force_sv = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sum_for(input int k);
    case (mode)
      0:       return 32'(100 - k);
      1:       return 32'd50;
      default: return (k == 13) ? 32'd7 : 32'd9;
    endcase
  endfunction

  // Monitor: every accepted issue and every Done pulse is checked against the queues.
  always @(negedge Clk) begin
    if (Reset) begin
      automatic int acc = (SadIssue && SadReady) ? 1 : 0;
      automatic int rt  = (SumValid && Busy && outst_tb > 0) ? 1 : 0;
      if (acc == 1) begin
        mon_iss++;
        check32("outstanding_bound", 32'(outst_tb < 4 || SumValid), 32'd1);
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_issue actual=%h required=none", SadAddr);
        end else begin
          check32("issue_addr", SadAddr, exp_addr_q.pop_front());
        end
      end
      outst_tb = outst_tb + acc - rt;
      if (Done) begin
        done_cnt++;
        check32("busy_in_done", 32'(Busy), 32'd0);
        if (exp_res_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=%h required=none", MinSum);
        end else begin
          automatic res_t e = exp_res_q.pop_front();
          check32("min_sum", MinSum, e.s);
          check32("min_row", 32'(MinRow), 32'(e.r));
          check32("min_col", 32'(MinCol), 32'(e.c));
        end
      end
    end
  end

  // One clock of the SAD pipeline model: latency 3, in order, optional result hold-off.
  task automatic cyc();
    @(negedge Clk);
    if (SadIssue && SadReady) begin
      pend_q.push_back('{due: cyc_n + 3, s: sum_for(acc_cnt)});
      acc_cnt++;
    end
    @(posedge Clk);
    #1;
    cyc_n++;
    SadReady = (ready_mode != 0) ? ~SadReady : 1'b1;
    if (hold > 0) hold--;
    SumValid = 1'b0;
    Sum      = 32'd0;
    if (force_sv) begin
      SumValid = 1'b1;
    end else if (hold == 0 && pend_q.size() > 0 && pend_q[0].due <= cyc_n) begin
      SumValid = 1'b1;
      Sum      = pend_q.pop_front().s;
    end
  endtask

  task automatic push_addrs(input logic [31:0] base);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        exp_addr_q.push_back(base + 32'((r * 8 + c) * 4));
  endtask

  task automatic run_search(input int mode_i, input int rdy_i, input int hold_i, input bit sdrain,
                            input logic [31:0] base, input res_t exp);
    int d0, i0;
    bit sd_done;
    mode = mode_i;
    ready_mode = rdy_i;
    acc_cnt = 0;
    sd_done = 1'b0;
    d0 = done_cnt;
    i0 = mon_iss;
    push_addrs(base);
    exp_res_q.push_back(exp);
    FrameBase = base;
    hold = hold_i;
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    check32("busy_after_start", 32'(Busy), 32'd1);
    if (hold_i > 0) begin
      repeat (7) cyc();
      check32("issues_while_withheld", 32'(mon_iss - i0), 32'd4);
    end
    for (int i = 0; i < 2000 && done_cnt == d0; i++) begin
      if (sdrain && !sd_done && (mon_iss - i0) == 25) begin
        hold = 4;
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        check32("busy_after_drain_start", 32'(Busy), 32'd1);
        sd_done = 1'b1;
      end
      cyc();
    end
    if (done_cnt == d0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required=done");
    end
    repeat (3) cyc();
    ready_mode = 0;
    check32("done_pulses", 32'(done_cnt - d0), 32'd1);
    check32("issue_count", 32'(mon_iss - i0), 32'd25);
    check32("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    int d0, nb, got;
    logic [31:0] ab;
    Reset = 1'b1; Start = 1'b0; SadReady = 1'b1; SumValid = 1'b0; Sum = '0;
    FrameBase = 32'h0000_1000;
    Start_b = 1'b0; SadReady_b = 1'b1; SumValid_b = 1'b0; Sum_b = '0;
    FrameBase_b = 32'h0000_2000;
    #1 Reset = 1'b0;
    #1;
    check32("rst_issue", 32'(SadIssue), 32'd0);
    check32("rst_addr", SadAddr, 32'd0);
    check32("rst_busy", 32'(Busy), 32'd0);
    check32("rst_done", 32'(Done), 32'd0);
    check32("rst_minsum", MinSum, 32'hFFFF_FFFF);
    check32("rst_minpos", {16'd0, MinRow, MinCol}, 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset = 1'b1;
    @(posedge Clk); #1;

    run_search(0, 0, 0, 1'b0, 32'h0000_1000, '{s: 32'd76, r: 8'd4, c: 8'd4});
    run_search(1, 0, 0, 1'b0, 32'h0000_4000, '{s: 32'd50, r: 8'd0, c: 8'd0});
    run_search(2, 1, 0, 1'b0, 32'h0000_0100, '{s: 32'd7,  r: 8'd2, c: 8'd3});
    run_search(0, 0, 10, 1'b0, 32'h0000_1000, '{s: 32'd76, r: 8'd4, c: 8'd4});
    run_search(0, 0, 0, 1'b1, 32'hFFFF_FFF0, '{s: 32'd76, r: 8'd4, c: 8'd4});

    // SumValid while idle must leave the held minimum alone.
    d0 = done_cnt;
    force_sv = 1'b1;
    repeat (5) cyc();
    force_sv = 1'b0;
    cyc();
    check32("idle_sv_minsum", MinSum, 32'd76);
    check32("idle_sv_minpos", {16'd0, MinRow, MinCol}, 32'h0000_0404);
    check32("idle_sv_busy", 32'(Busy), 32'd0);
    check32("idle_sv_done", 32'(done_cnt - d0), 32'd0);

    // Abort a search with reset as the 12th request is presented.
    mode = 0; acc_cnt = 0; d0 = done_cnt;
    push_addrs(32'h0000_8000);
    FrameBase = 32'h0000_8000;
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    for (int i = 0; i < 200 && acc_cnt < 11; i++) cyc();
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check32("abort_issue", 32'(SadIssue), 32'd0);
    check32("abort_addr", SadAddr, 32'd0);
    check32("abort_busy", 32'(Busy), 32'd0);
    check32("abort_minsum", MinSum, 32'hFFFF_FFFF);
    check32("abort_minpos", {16'd0, MinRow, MinCol}, 32'd0);
    exp_addr_q.delete();
    pend_q.delete();
    outst_tb = 0;
    SumValid = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset = 1'b1;
    @(posedge Clk); #1;
    check32("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_search(0, 0, 0, 1'b0, 32'h0000_1000, '{s: 32'd76, r: 8'd4, c: 8'd4});

    // WIN equal to the frame: a single candidate.
    @(posedge Clk); #1 Start_b = 1'b1;
    @(posedge Clk); #1 Start_b = 1'b0;
    nb = 0; ab = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (SadIssue_b) begin nb++; ab = SadAddr_b; end
    end
    check32("b_issue_count", 32'(nb), 32'd1);
    check32("b_issue_addr", ab, 32'h0000_2000);
    @(posedge Clk); #1 SumValid_b = 1'b1; Sum_b = 32'd33;
    @(posedge Clk); #1 SumValid_b = 1'b0; Sum_b = 32'd0;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge Clk);
      if (Done_b) got = 1;
    end
    check32("b_done_seen", 32'(got), 32'd1);
    check32("b_minsum", MinSum_b, 32'd33);
    check32("b_minpos", {16'd0, MinRow_b, MinCol_b}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sad_search_ctrl.md
Name: sad_search_ctrl

Overview:
Sequencer for the 3-stage SAD datapath during a block-matching search. On Start it walks every WIN x WIN candidate position of a FRAME_W x FRAME_H reference frame in raster order and issues one SAD request per position. It collects the in-order sums returned by the final SAD stage and reports the minimum sum and its (row, col). It sits between the control unit (start/done) and the SAD pipeline issue and result ports.

Parameters:
FRAME_W, 64, reference frame width in pixels.
FRAME_H, 64, reference frame height in pixels.
WIN, 4, candidate block edge; WIN <= FRAME_W and WIN <= FRAME_H.
MAX_OUT, 4, maximum SAD requests in flight (pipeline depth plus slack).

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-low reset.
Start  in  1  one-cycle pulse that begins a search; ignored unless in IDLE.
FrameBase  in  32  byte address of frame pixel (0,0).
SadReady  in  1  SAD pipeline can accept a request this cycle.
SadIssue  out  1  request valid; accepted when SadIssue && SadReady.
SadAddr  out  32  byte address of candidate top-left = FrameBase + (row*FRAME_W + col)*4.
SumValid  in  1  a result is present on Sum (in issue order).
Sum  in  32  SAD value from the final stage.
Busy  out  1  high from the cycle after Start until Done.
Done  out  1  one-cycle pulse when the last result is absorbed.
MinSum  out  32  smallest Sum of the last completed search.
MinRow  out  8  row of MinSum.
MinCol  out  8  column of MinSum.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE; SadIssue=0; SadAddr=0; Busy=0; Done=0; MinSum=32'hFFFFFFFF; MinRow=0; MinCol=0; all counters 0. Reset mid-search aborts it with no Done.
- NROW=FRAME_H-WIN+1, NCOL=FRAME_W-WIN+1, N=NROW*NCOL candidates.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on Start, latch FrameBase, clear issue/return counters, reset tracker to MinSum=FFFFFFFF, go ISSUE. SumValid in IDLE is ignored.
- ISSUE: SadIssue=1 when outstanding < MAX_OUT, or outstanding==MAX_OUT with SumValid in the same cycle. The issue position advances only on acceptance: col++; at col==NCOL-1 wrap col=0, row++. After the N-th acceptance go DRAIN. SadAddr is registered and valid whenever SadIssue=1.
- DRAIN: SadIssue=0. Wait until the return count reaches N, then go DONE.
- DONE: Done=1 for exactly one cycle, then IDLE. Busy is 0 in DONE.
- outstanding = issued - returned. An issue and a return in the same cycle leave it unchanged. It never exceeds MAX_OUT and never underflows; a SumValid with outstanding==0 is ignored.
- Tracker: position fields are captured at issue and kept in a MAX_OUT-entry FIFO popped on SumValid. When Sum < MinSum (strict, unsigned), MinSum/MinRow/MinCol update. Ties keep the earliest (raster) position.
- MinSum/MinRow/MinCol hold their values after Done until the next Start.
- Start during ISSUE, DRAIN or DONE is ignored.
- Address arithmetic is modulo 2^32.

Decomposition:
- Package sad_ctrl_pkg: state enum (IDLE, ISSUE, DRAIN, DONE), SUM_MAX=32'hFFFFFFFF, and the position type {row[7:0], col[7:0]}.
- One sub-module, sad_min_tracker: the position FIFO (depth MAX_OUT) plus the running-minimum compare and register.

Test Plan:
- FRAME_W=FRAME_H=8, WIN=4, SadReady=1, lat 3, Sum=100-k for k-th result -> 25 issues at addrs FrameBase+{0,4,8,12,16,32,...}; Done once; MinSum=76, MinRow=4, MinCol=4.
- Same config, all Sums=50 -> MinSum=50, MinRow=0, MinCol=0 (tie keeps first).
- SadReady toggling 1/0 each cycle, Sum=7 only at (2,3) else 9 -> exactly 25 accepted, no duplicates; MinRow=2, MinCol=3.
- Results withheld for 10 cycles -> exactly MAX_OUT=4 issues, then issue resumes one per returned SumValid; outstanding never exceeds 4.
- Reset low at the 12th issue -> all outputs go to reset values immediately, no Done; a fresh Start completes normally.
- Start pulsed during DRAIN, and SumValid while in IDLE -> no state change and min outputs unchanged; WIN=FRAME_W=FRAME_H=8 -> single issue at FrameBase, Done after one result.
